// File: rtl/elevator_pkg.sv
// Shared floor geometry, service direction encoding and scan-mode type for the elevator call path.
package elevator_pkg;
  localparam int FLOOR_COUNT = 10;
  localparam int FLOOR_W     = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    SCAN_LOWEST_ABOVE  = 1'b0,
    SCAN_HIGHEST_BELOW = 1'b1
  } scan_mode_e;
endpackage

// File: rtl/floor_priority_scan.sv
// Finds the nearest set floor strictly above (lowest) or strictly below (highest) pos.
// Purely combinational; idx falls back to pos when nothing qualifies.
module floor_priority_scan
  import elevator_pkg::*;
#(
  parameter int N = FLOOR_COUNT,
  parameter int W = FLOOR_W
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] pos,
  input  scan_mode_e   mode,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan away from pos so the last hit written is the closest one.
  always_comb begin
    idx   = pos;
    found = 1'b0;
    if (mode == SCAN_LOWEST_ABOVE) begin
      for (int f = N - 1; f >= 0; f--) begin
        if (vec[f] && (W'(f) > pos)) begin
          idx   = W'(f);
          found = 1'b1;
        end
      end
    end else begin
      for (int f = 0; f < N; f++) begin
        if (vec[f] && (W'(f) < pos)) begin
          idx   = W'(f);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_call_register.sv
// Edge-detects hall/cabin buttons into above/below pending bitmaps, cleared by FSM service pulses.
// Pending bits visible one cycle after the button edge; summaries are combinational from them.
module elevator_call_register #(
  parameter int FLOOR_COUNT = elevator_pkg::FLOOR_COUNT,
  parameter int FLOOR_W     = elevator_pkg::FLOOR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [FLOOR_W-1:0]     position,
  input  logic [FLOOR_COUNT-1:0] hall_up_btn,
  input  logic [FLOOR_COUNT-1:0] hall_down_btn,
  input  logic [FLOOR_COUNT-1:0] cabin_btn,
  input  logic                   service_valid,
  input  logic                   service_dir,
  output logic [FLOOR_COUNT-1:0] up_pending,
  output logic [FLOOR_COUNT-1:0] down_pending,
  output logic [FLOOR_W:0]       count_up,
  output logic [FLOOR_W:0]       count_down,
  output logic [FLOOR_W-1:0]     nearest_up,
  output logic [FLOOR_W-1:0]     nearest_down,
  output logic                   has_up,
  output logic                   has_down,
  output logic                   here_req,
  output logic                   pos_err
);
  import elevator_pkg::*;

  logic [FLOOR_COUNT-1:0] up_q, up_d, down_q, down_d;
  logic [FLOOR_COUNT-1:0] prev_hall_up_q, prev_hall_up_d;
  logic [FLOOR_COUNT-1:0] prev_hall_down_q, prev_hall_down_d;
  logic [FLOOR_COUNT-1:0] prev_cabin_q, prev_cabin_d;
  logic                   here_q, here_d, pos_err_q, pos_err_d;
  logic [FLOOR_COUNT-1:0] rise, above_mask, below_mask, at_mask;
  logic                   pos_ok;

  always_comb begin
    for (int f = 0; f < FLOOR_COUNT; f++) begin
      at_mask[f]    = (FLOOR_W'(f) == position);
      above_mask[f] = (FLOOR_W'(f) > position);
      below_mask[f] = (FLOOR_W'(f) < position);
    end
  end

  assign pos_ok = ((FLOOR_W + 1)'(position) < (FLOOR_W + 1)'(FLOOR_COUNT));
  assign rise   = (hall_up_btn & ~prev_hall_up_q) | (hall_down_btn & ~prev_hall_down_q)
                | (cabin_btn & ~prev_cabin_q);

  always_comb begin
    prev_hall_up_d   = hall_up_btn;
    prev_hall_down_d = hall_down_btn;
    prev_cabin_d     = cabin_btn;
    up_d             = up_q;
    down_d           = down_q;
    here_d           = 1'b0;
    pos_err_d        = pos_err_q;
    if (pos_ok) begin
      up_d   = up_q | (rise & above_mask);
      down_d = down_q | (rise & below_mask);
      here_d = |(rise & at_mask);
      // Set never targets the current floor, so clearing it afterwards cannot mask a new call.
      if (service_valid) begin
        if (service_dir == DIR_UP) up_d = up_d & ~at_mask;
        else if (service_dir == DIR_DOWN) down_d = down_d & ~at_mask;
      end
    end else begin
      pos_err_d = 1'b1;
    end
  end

  // History keeps tracking the buttons through reset so a button held across it is not a new call.
  always_ff @(posedge clock) begin
    prev_hall_up_q   <= prev_hall_up_d;
    prev_hall_down_q <= prev_hall_down_d;
    prev_cabin_q     <= prev_cabin_d;
    if (reset) begin
      up_q      <= '0;
      down_q    <= '0;
      here_q    <= 1'b0;
      pos_err_q <= 1'b0;
    end else begin
      up_q      <= up_d;
      down_q    <= down_d;
      here_q    <= here_d;
      pos_err_q <= pos_err_d;
    end
  end

  always_comb begin
    count_up   = '0;
    count_down = '0;
    for (int f = 0; f < FLOOR_COUNT; f++) begin
      count_up   = count_up + (FLOOR_W + 1)'(up_q[f]);
      count_down = count_down + (FLOOR_W + 1)'(down_q[f]);
    end
  end

  floor_priority_scan #(.N(FLOOR_COUNT), .W(FLOOR_W)) u_scan_up (
    .vec   (up_q),
    .pos   (position),
    .mode  (SCAN_LOWEST_ABOVE),
    .idx   (nearest_up),
    .found (has_up)
  );

  floor_priority_scan #(.N(FLOOR_COUNT), .W(FLOOR_W)) u_scan_down (
    .vec   (down_q),
    .pos   (position),
    .mode  (SCAN_HIGHEST_BELOW),
    .idx   (nearest_down),
    .found (has_down)
  );

  assign up_pending   = up_q;
  assign down_pending = down_q;
  assign here_req     = here_q;
  assign pos_err      = pos_err_q;

endmodule
